// File: rtl/trace_window_ctrl.sv
// Trace window capture controller.
// Records a sample stream into a circular buffer and freezes the window of
// pre_len samples before a trigger, the trigger sample itself, and post_len
// samples after it. The frozen window is then replayed oldest-first over a
// valid/ready stream.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | nothing recorded; waits for arm
//   PRE   | filling the pre-trigger history; triggers only flag early_trig
//   WAIT  | free-running circular recording; waits for a qualified trigger
//   POST  | recording the post-trigger tail; rem_q counts down to zero
//   READ  | replaying the frozen window; no buffer writes
module trace_window_ctrl #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 256,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [AW-1:0]     pre_len,
    input  logic [AW-1:0]     post_len,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              trig_in,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [2:0]        state_o,
    output logic [AW-1:0]     trig_addr,
    output logic              early_trig,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_READ = 3'd4
    } state_e;

    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   ONE_T = {{AW{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     pre_q, pre_d;
    logic [AW-1:0]     post_eff_q, post_eff_d;
    logic [AW:0]       total_q, total_d;
    logic [AW-1:0]     rem_q, rem_d;
    logic [AW-1:0]     trig_addr_q, trig_addr_d;
    logic              early_q, early_d;
    logic              done_q, done_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       issued_q, issued_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic              rd_load;
    logic [AW-1:0]     post_room;
    logic [AW-1:0]     post_clamp;
    logic [AW:0]       total_arm;

    // The post window may use whatever the pre window leaves of the buffer
    // after the trigger slot: DEPTH-1-pre_len, which in AW bits is ~pre_len.
    always_comb begin
        post_room  = ~pre_len;
        post_clamp = (post_len < post_room) ? post_len : post_room;
        total_arm  = {1'b0, pre_len} + {1'b0, post_clamp} + ONE_T;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            post_eff_q  <= '0;
            total_q     <= '0;
            rem_q       <= '0;
            trig_addr_q <= '0;
            early_q     <= 1'b0;
            done_q      <= 1'b0;
            rd_ptr_q    <= '0;
            issued_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            post_eff_q  <= post_eff_d;
            total_q     <= total_d;
            rem_q       <= rem_d;
            trig_addr_q <= trig_addr_d;
            early_q     <= early_d;
            done_q      <= done_d;
            rd_ptr_q    <= rd_ptr_d;
            issued_q    <= issued_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    // Next-state logic: abort wins, then arm (IDLE only), then sample/trigger.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        post_eff_d  = post_eff_q;
        total_d     = total_q;
        rem_d       = rem_q;
        trig_addr_d = trig_addr_q;
        early_d     = early_q;
        done_d      = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        issued_d    = issued_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        wr_en       = 1'b0;
        rd_load     = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        wr_ptr_d   = '0;
                        cnt_d      = '0;
                        early_d    = 1'b0;
                        pre_d      = pre_len;
                        post_eff_d = post_clamp;
                        total_d    = total_arm;
                        state_d    = (pre_len != '0) ? ST_PRE : ST_WAIT;
                    end
                end

                ST_PRE: begin
                    if (sample_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_A;
                        cnt_d    = cnt_q + ONE_A;
                        if (trig_in) begin
                            early_d = 1'b1;
                        end
                        if (cnt_q + ONE_A == pre_q) begin
                            state_d = ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (sample_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_A;
                        if (trig_in) begin
                            trig_addr_d = wr_ptr_q;
                            rem_d       = post_eff_q;
                            if (post_eff_q == '0) begin
                                state_d  = ST_READ;
                                rd_ptr_d = wr_ptr_q - pre_q;
                                issued_d = '0;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end
                end

                ST_POST: begin
                    if (sample_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_A;
                        rem_d    = rem_q - ONE_A;
                        if (rem_q == ONE_A) begin
                            state_d  = ST_READ;
                            rd_ptr_d = trig_addr_q - pre_q;
                            issued_d = '0;
                        end
                    end
                end

                ST_READ: begin
                    if (rd_valid_q && rd_ready) begin
                        rd_valid_d = 1'b0;
                        if (rd_last_q) begin
                            rd_last_d = 1'b0;
                            state_d   = ST_IDLE;
                            done_d    = 1'b1;
                        end
                    end
                    // Refill the output register whenever it is empty or being
                    // drained this cycle, so a steady rd_ready gets one word
                    // per cycle while a stalled word stays put.
                    if ((issued_q != total_q) && (!rd_valid_q || rd_ready)) begin
                        rd_load    = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_last_d  = (issued_q + ONE_T == total_q);
                        rd_ptr_d   = rd_ptr_q + ONE_A;
                        issued_d   = issued_q + ONE_T;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sample buffer write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // Registered buffer read port doubling as the readout data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_load) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign state_o    = state_q;
    assign trig_addr  = trig_addr_q;
    assign early_trig = early_q;
    assign done       = done_q;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_trace_window_ctrl.sv
// Directed bench for trace_window_ctrl with DEPTH=16.
module tb_trace_window_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              clk;
    logic              rst_n;
    logic              arm;
    logic              abort;
    logic [AW-1:0]     pre_len;
    logic [AW-1:0]     post_len;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_in;
    logic              trig_in;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic [2:0]        state_o;
    logic [AW-1:0]     trig_addr;
    logic              early_trig;
    logic              done;

    int n_vec  = 0;
    int n_miss = 0;

    trace_window_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .pre_len      (pre_len),
        .post_len     (post_len),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .trig_in      (trig_in),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .state_o      (state_o),
        .trig_addr    (trig_addr),
        .early_trig   (early_trig),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    pre;
        int    post;
        int    trig;    // sample value carrying the real trigger
        int    e_lo;    // trigger also driven for samples e_lo..e_hi (PRE phase)
        int    e_hi;
        bit    gaps;    // random sample_valid gaps
        bit    stall;   // rd_ready toggles 1,0,1,0
        int    first;   // expected first readout word
        int    total;   // expected word count
        int    taddr;   // expected trig_addr
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_capture(input vec_t v);
        int  seq;
        int  cyc;
        int  k;
        bit  stalled;
        logic [DATA_W-1:0] held_d;
        logic              held_l;

        arm      = 1'b1;
        pre_len  = AW'(v.pre);
        post_len = AW'(v.post);
        tick();
        arm = 1'b0;
        check({v.name, " state_after_arm"}, 64'(state_o), (v.pre > 0) ? 64'd1 : 64'd2);
        check({v.name, " early_clr_on_arm"}, 64'(early_trig), 64'd0);

        seq = 0;
        cyc = 0;
        while (state_o != 3'd4 && cyc < 400) begin
            sample_valid = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            sample_in    = DATA_W'(seq);
            trig_in      = sample_valid && (seq == v.trig || (seq >= v.e_lo && seq <= v.e_hi));
            tick();
            if (sample_valid) seq++;
            cyc++;
        end
        sample_valid = 1'b0;
        trig_in      = 1'b0;
        check({v.name, " reached_read"}, 64'(state_o), 64'd4);
        check({v.name, " trig_addr"}, 64'(trig_addr), 64'(v.taddr));
        check({v.name, " early_trig"}, 64'(early_trig), (v.e_lo >= 0) ? 64'd1 : 64'd0);

        k       = 0;
        cyc     = 0;
        stalled = 1'b0;
        held_d  = '0;
        held_l  = 1'b0;
        while (k < v.total && cyc < 200) begin
            rd_ready = v.stall ? (cyc % 2 == 0) : 1'b1;
            if (rd_valid) begin
                if (rd_ready) begin
                    check({v.name, " rd_data"}, 64'(rd_data), 64'(v.first + k));
                    check({v.name, " rd_last"}, 64'(rd_last), (k == v.total - 1) ? 64'd1 : 64'd0);
                    k++;
                end else begin
                    held_d  = rd_data;
                    held_l  = rd_last;
                    stalled = 1'b1;
                end
            end
            tick();
            cyc++;
            if (stalled) begin
                check({v.name, " stall_valid"}, 64'(rd_valid), 64'd1);
                check({v.name, " stall_data"}, 64'(rd_data), 64'(held_d));
                check({v.name, " stall_last"}, 64'(rd_last), 64'(held_l));
                stalled = 1'b0;
            end
        end
        rd_ready = 1'b0;
        check({v.name, " word_count"}, 64'(k), 64'(v.total));
        check({v.name, " done_pulse"}, 64'(done), 64'd1);
        check({v.name, " idle_after"}, 64'(state_o), 64'd0);
        check({v.name, " valid_drop"}, 64'(rd_valid), 64'd0);
        tick();
        check({v.name, " done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int   seq;
        int   cyc;
        vec_t v5;

        vecs[0] = '{"basic",      4,  3, 10, -1, -1, 1'b0, 1'b0,  6,  8, 10};
        vecs[1] = '{"wrap",       4,  3, 17, -1, -1, 1'b0, 1'b0, 13,  8,  1};
        vecs[2] = '{"clamp",     10, 10, 30, -1, -1, 1'b0, 1'b0, 20, 16, 14};
        vecs[3] = '{"stall_gap",  4,  3, 10, -1, -1, 1'b1, 1'b1,  6,  8, 10};
        vecs[4] = '{"early",      8,  2, 12,  3,  7, 1'b0, 1'b0,  4, 11, 12};
        vecs[5] = '{"zero_win",   0,  0,  5, -1, -1, 1'b0, 1'b0,  5,  1,  5};
        vecs[6] = '{"full_pre",  15,  7, 20, -1, -1, 1'b0, 1'b1,  5, 16,  4};

        rst_n        = 1'b0;
        arm          = 1'b0;
        abort        = 1'b0;
        pre_len      = '0;
        post_len     = '0;
        sample_valid = 1'b0;
        sample_in    = '0;
        trig_in      = 1'b0;
        rd_ready     = 1'b0;

        tick();
        tick();
        check("reset state", 64'(state_o), 64'd0);
        check("reset rd_valid", 64'(rd_valid), 64'd0);
        check("reset rd_last", 64'(rd_last), 64'd0);
        check("reset rd_data", 64'(rd_data), 64'd0);
        check("reset trig_addr", 64'(trig_addr), 64'd0);
        check("reset early", 64'(early_trig), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle after reset", 64'(state_o), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_capture(vecs[i]);
        end

        // Abort two samples into POST; arm asserted alongside abort must be ignored.
        arm      = 1'b1;
        pre_len  = 4'd4;
        post_len = 4'd3;
        tick();
        arm = 1'b0;
        seq = 0;
        cyc = 0;
        while (state_o != 3'd3 && cyc < 100) begin
            sample_valid = 1'b1;
            sample_in    = DATA_W'(seq);
            trig_in      = (seq == 10);
            tick();
            seq++;
            cyc++;
        end
        trig_in = 1'b0;
        check("abort reached_post", 64'(state_o), 64'd3);
        for (int i = 0; i < 2; i++) begin
            sample_in = DATA_W'(seq);
            tick();
            seq++;
        end
        check("abort still_post", 64'(state_o), 64'd3);
        abort     = 1'b1;
        arm       = 1'b1;
        sample_in = DATA_W'(seq);
        tick();
        abort        = 1'b0;
        arm          = 1'b0;
        sample_valid = 1'b0;
        check("abort state", 64'(state_o), 64'd0);
        check("abort rd_valid", 64'(rd_valid), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort trig_addr_kept", 64'(trig_addr), 64'd10);
        tick();
        check("abort stays_idle", 64'(state_o), 64'd0);
        check("abort no_done", 64'(done), 64'd0);

        v5 = '{"rearm", 0, 0, 50, -1, -1, 1'b0, 1'b0, 50, 1, 2};
        run_capture(v5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
